// File: rtl/noc_mm_pkg.sv
// Shared definitions for the NoC matrix-multiply tile scheduler.
package noc_mm_pkg;

  // Descriptor type codes driven on cmd_type.
  localparam logic [1:0] CMD_A = 2'd0;
  localparam logic [1:0] CMD_B = 2'd1;
  localparam logic [1:0] CMD_D = 2'd2;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Scheduler states, in the order a successful job walks through them.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ISSUE_A = 3'd2,
    S_ISSUE_B = 3'd3,
    S_ISSUE_D = 3'd4,
    S_NEXT    = 3'd5,
    S_DRAIN   = 3'd6,
    S_FIN     = 3'd7
  } state_e;

  // Bytes occupied by one element of the given bit width.
  function automatic int unsigned elem_bytes(input int unsigned width_bits);
    return width_bits / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/noc_mm_credit_cnt.sv
// Outstanding-write tracker: counts accepted D descriptors not yet acknowledged.
module noc_mm_credit_cnt
#(
  parameter int unsigned MAX_OUT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic underflow_o
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] count_q, count_d;

  // Next count; simultaneous inc and dec cancel, and the count never leaves 0..MAX_OUT.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != CW'(MAX_OUT))) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_o      = (count_q == CW'(MAX_OUT));
  assign empty_o     = (count_q == '0);
  // An acknowledge with nothing outstanding is spurious.
  assign underflow_o = dec_i & empty_o;

endmodule

// File: rtl/noc_mm_tile_sched.sv
// Batched tile scheduler: walks N1xN2 output tiles and issues A/B read and D write descriptors.
module noc_mm_tile_sched
  import noc_mm_pkg::*;
#(
  parameter int unsigned D_W          = 8,
  parameter int unsigned D_W_ACC      = 32,
  parameter int unsigned N1           = 2,
  parameter int unsigned N2           = 2,
  parameter int unsigned MATRIXSIZE_W = 24,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned MAX_OUT      = 8
) (
  input  logic                    clk_pl,
  input  logic                    rst_pl,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic [MATRIXSIZE_W-1:0] M1,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M3,
  input  logic [15:0]             batch,
  input  logic [ADDR_W-1:0]       addr_matrix_a,
  input  logic [ADDR_W-1:0]       addr_matrix_b,
  input  logic [ADDR_W-1:0]       addr_matrix_d,
  input  logic [ADDR_W-1:0]       stride_a,
  input  logic [ADDR_W-1:0]       stride_b,
  input  logic [ADDR_W-1:0]       stride_d,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [1:0]              cmd_type,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [31:0]             cmd_len,
  output logic                    cmd_tile_last,
  input  logic                    wr_ack
);

  localparam int unsigned EA   = elem_bytes(D_W);
  localparam int unsigned ED   = elem_bytes(D_W_ACC);
  localparam int unsigned NMAX = (N1 > N2) ? N1 : N2;
  localparam int unsigned RW   = $clog2(NMAX) + 1;
  localparam int unsigned SW   = MATRIXSIZE_W + 1;

  state_e                  state_q, state_d;
  logic [MATRIXSIZE_W-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic [MATRIXSIZE_W-1:0] row_q, row_d, col_q, col_d;
  logic [15:0]             batch_q, batch_d, bi_q, bi_d;
  logic [ADDR_W-1:0]       ba_q, ba_d, bb_q, bb_d, bd_q, bd_d;
  logic [ADDR_W-1:0]       sa_q, sa_d, sb_q, sb_d, sd_q, sd_d;
  logic [RW-1:0]           r_q, r_d;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic                    acc_s, d_acc_s, full_s, empty_s, underflow_s, dims_bad_s;
  logic [SW-1:0]           row_nx_s, col_nx_s;
  logic [16:0]             bi_nx_s;
  logic [ADDR_W-1:0]       line_s, a_idx_s, b_idx_s, d_off_s;

  noc_mm_credit_cnt #(.MAX_OUT(MAX_OUT)) u_credit (
    .clk_i       (clk_pl),
    .rst_i       (rst_pl),
    .inc_i       (d_acc_s),
    .dec_i       (wr_ack),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .underflow_o (underflow_s)
  );

  assign acc_s      = cmd_valid & cmd_ready;
  assign d_acc_s    = acc_s & (state_q == S_ISSUE_D);
  assign dims_bad_s = (m1_q == '0) | (m2_q == '0) | (m3_q == '0) | (batch_q == '0) |
                      ((m1_q % MATRIXSIZE_W'(N1)) != '0) | ((m3_q % MATRIXSIZE_W'(N2)) != '0);
  assign row_nx_s   = {1'b0, row_q} + SW'(N1);
  assign col_nx_s   = {1'b0, col_q} + SW'(N2);
  assign bi_nx_s    = {1'b0, bi_q} + 17'd1;

  // Address terms; row_q/col_q hold the first matrix row/column of the current tile.
  assign line_s  = ADDR_W'(m2_q) * ADDR_W'(EA);
  assign a_idx_s = ADDR_W'(row_q) + ADDR_W'(r_q);
  assign b_idx_s = ADDR_W'(col_q) + ADDR_W'(r_q);
  assign d_off_s = (a_idx_s * ADDR_W'(m3_q) + ADDR_W'(col_q)) * ADDR_W'(ED);

  // Descriptor decode from registered state; fields only move on acceptance, so they hold while stalled.
  always_comb begin
    cmd_valid     = 1'b0;
    cmd_type      = CMD_A;
    cmd_addr      = '0;
    cmd_len       = '0;
    cmd_tile_last = 1'b0;
    case (state_q)
      S_ISSUE_A: begin
        cmd_valid = 1'b1;
        cmd_type  = CMD_A;
        cmd_addr  = ba_q + a_idx_s * line_s;
        cmd_len   = 32'(m2_q) * 32'(EA);
      end
      S_ISSUE_B: begin
        cmd_valid = 1'b1;
        cmd_type  = CMD_B;
        cmd_addr  = bb_q + b_idx_s * line_s;
        cmd_len   = 32'(m2_q) * 32'(EA);
      end
      S_ISSUE_D: begin
        cmd_valid     = ~full_s;
        cmd_type      = CMD_D;
        cmd_addr      = bd_q + d_off_s;
        cmd_len       = 32'(N2 * ED);
        cmd_tile_last = (r_q == RW'(N1 - 1));
      end
      default: begin
        cmd_valid = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update for the tile walk.
  always_comb begin
    state_d = state_q;
    m1_d = m1_q;  m2_d = m2_q;  m3_d = m3_q;  batch_d = batch_q;
    ba_d = ba_q;  bb_d = bb_q;  bd_d = bd_q;
    sa_d = sa_q;  sb_d = sb_q;  sd_d = sd_q;
    row_d = row_q;  col_d = col_q;  bi_d = bi_q;  r_d = r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q | (underflow_s & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m1_d = M1;  m2_d = M2;  m3_d = M3;  batch_d = batch;
          ba_d = addr_matrix_a;  bb_d = addr_matrix_b;  bd_d = addr_matrix_d;
          sa_d = stride_a;  sb_d = stride_b;  sd_d = stride_d;
          row_d = '0;  col_d = '0;  bi_d = '0;  r_d = '0;
          busy_d = 1'b1;  done_d = 1'b0;  error_d = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (dims_bad_s) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_ISSUE_A;
        end
      end
      S_ISSUE_A: begin
        if (acc_s && (r_q == RW'(N1 - 1))) begin
          r_d = '0;
          state_d = S_ISSUE_B;
        end else if (acc_s) begin
          r_d = r_q + RW'(1);
        end else begin
          r_d = r_q;
        end
      end
      S_ISSUE_B: begin
        if (acc_s && (r_q == RW'(N2 - 1))) begin
          r_d = '0;
          state_d = S_ISSUE_D;
        end else if (acc_s) begin
          r_d = r_q + RW'(1);
        end else begin
          r_d = r_q;
        end
      end
      S_ISSUE_D: begin
        if (acc_s && (r_q == RW'(N1 - 1))) begin
          r_d = '0;
          state_d = S_NEXT;
        end else if (acc_s) begin
          r_d = r_q + RW'(1);
        end else begin
          r_d = r_q;
        end
      end
      S_NEXT: begin
        if (col_nx_s < {1'b0, m3_q}) begin
          col_d = col_nx_s[MATRIXSIZE_W-1:0];
          state_d = S_ISSUE_A;
        end else if (row_nx_s < {1'b0, m1_q}) begin
          col_d = '0;
          row_d = row_nx_s[MATRIXSIZE_W-1:0];
          state_d = S_ISSUE_A;
        end else if (bi_nx_s < {1'b0, batch_q}) begin
          col_d = '0;
          row_d = '0;
          bi_d  = bi_nx_s[15:0];
          ba_d  = ba_q + sa_q;
          bb_d  = bb_q + sb_q;
          bd_d  = bd_q + sd_q;
          state_d = S_ISSUE_A;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty_s) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_pl) begin
    if (rst_pl) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job parameters, tile counters and status flags.
  always_ff @(posedge clk_pl) begin
    if (rst_pl) begin
      m1_q <= '0;  m2_q <= '0;  m3_q <= '0;  batch_q <= '0;
      ba_q <= '0;  bb_q <= '0;  bd_q <= '0;
      sa_q <= '0;  sb_q <= '0;  sd_q <= '0;
      row_q <= '0;  col_q <= '0;  bi_q <= '0;  r_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;
    end else begin
      m1_q <= m1_d;  m2_q <= m2_d;  m3_q <= m3_d;  batch_q <= batch_d;
      ba_q <= ba_d;  bb_q <= bb_d;  bd_q <= bd_d;
      sa_q <= sa_d;  sb_q <= sb_d;  sd_q <= sd_d;
      row_q <= row_d;  col_q <= col_d;  bi_q <= bi_d;  r_q <= r_d;
      busy_q <= busy_d;  done_q <= done_d;  error_q <= error_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_noc_mm_tile_sched.sv
// Self-checking bench for noc_mm_tile_sched: job table, hand sequences and random jobs vs a loop model.
module tb_noc_mm_tile_sched;

  localparam int unsigned TN1 = 2;
  localparam int unsigned TN2 = 2;
  localparam int unsigned EA  = 1;
  localparam int unsigned ED  = 4;
  localparam int unsigned MAXO = 8;

  logic        clk_pl = 1'b0;
  logic        rst_pl = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [23:0] M1 = '0, M2 = '0, M3 = '0;
  logic [15:0] batch = '0;
  logic [63:0] addr_matrix_a = '0, addr_matrix_b = '0, addr_matrix_d = '0;
  logic [63:0] stride_a = '0, stride_b = '0, stride_d = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [1:0]  cmd_type;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_len;
  logic        cmd_tile_last;
  logic        wr_ack = 1'b0;

  noc_mm_tile_sched #(
    .D_W(8), .D_W_ACC(32), .N1(TN1), .N2(TN2), .MATRIXSIZE_W(24), .ADDR_W(64), .MAX_OUT(MAXO)
  ) dut (
    .clk_pl(clk_pl), .rst_pl(rst_pl), .start(start), .busy(busy), .done(done), .error(error),
    .M1(M1), .M2(M2), .M3(M3), .batch(batch),
    .addr_matrix_a(addr_matrix_a), .addr_matrix_b(addr_matrix_b), .addr_matrix_d(addr_matrix_d),
    .stride_a(stride_a), .stride_b(stride_b), .stride_d(stride_d),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_tile_last(cmd_tile_last), .wr_ack(wr_ack)
  );

  always #5 clk_pl = ~clk_pl;

  typedef struct {
    int unsigned m1, m2, m3, batch;
    logic [63:0] a, b, d, sa, sb, sd;
    int          exp_n;
    bit          exp_err;
    bit          rnd;
    bit          hold;
    bit          spur;
  } job_t;

  typedef struct {
    logic [1:0]  t;
    logic [63:0] addr;
    logic [31:0] len;
    logic        last;
  } desc_t;

  int    checks = 0;
  int    errors = 0;
  desc_t exp_q[$];
  desc_t log_q[$];
  int    acks_owed = 0;
  bit    ack_auto = 1'b1;
  bit    spur_req = 1'b0;
  bit    rnd_ready = 1'b0;
  int    job_acc = 0;
  int    job_d = 0;
  bit    prev_stall = 1'b0;
  logic [63:0] prev_addr;
  logic [34:0] prev_misc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: the descriptor stream written directly from the layout formulas.
  task automatic build_exp(input job_t j);
    desc_t dsc;
    logic [63:0] row_b;
    exp_q.delete();
    if (j.m1 == 0 || j.m2 == 0 || j.m3 == 0 || j.batch == 0 ||
        (j.m1 % TN1) != 0 || (j.m3 % TN2) != 0) return;
    row_b = 64'(j.m2) * 64'(EA);
    for (int bi = 0; bi < int'(j.batch); bi++)
      for (int ti = 0; ti < int'(j.m1 / TN1); ti++)
        for (int tj = 0; tj < int'(j.m3 / TN2); tj++) begin
          for (int r = 0; r < int'(TN1); r++) begin
            dsc.t = 2'd0; dsc.last = 1'b0; dsc.len = row_b[31:0];
            dsc.addr = j.a + 64'(bi) * j.sa + 64'(ti * int'(TN1) + r) * row_b;
            exp_q.push_back(dsc);
          end
          for (int c = 0; c < int'(TN2); c++) begin
            dsc.t = 2'd1; dsc.last = 1'b0; dsc.len = row_b[31:0];
            dsc.addr = j.b + 64'(bi) * j.sb + 64'(tj * int'(TN2) + c) * row_b;
            exp_q.push_back(dsc);
          end
          for (int r = 0; r < int'(TN1); r++) begin
            dsc.t = 2'd2; dsc.last = (r == int'(TN1) - 1); dsc.len = 32'(TN2 * ED);
            dsc.addr = j.d + 64'(bi) * j.sd +
                       (64'(ti * int'(TN1) + r) * 64'(j.m3) + 64'(tj * int'(TN2))) * 64'(ED);
            exp_q.push_back(dsc);
          end
        end
  endtask

  // Input driver for cmd_ready and wr_ack, updated 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk_pl);
      #2;
      cmd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ack_auto && acks_owed > 0) begin
        wr_ack = 1'b1;
        acks_owed--;
      end else begin
        wr_ack = spur_req;
      end
    end
  end

  // Monitor on the falling edge: scoreboard accepted descriptors and check stall stability.
  always @(negedge clk_pl) begin
    desc_t dsc;
    if (!rst_pl) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(cmd_valid), 64'd1);
        chk("stall_addr", cmd_addr, prev_addr);
        chk("stall_fields", 64'({cmd_type, cmd_tile_last, cmd_len}), 64'(prev_misc));
      end
      if (cmd_valid && cmd_ready) begin
        dsc.t = cmd_type; dsc.addr = cmd_addr; dsc.len = cmd_len; dsc.last = cmd_tile_last;
        log_q.push_back(dsc);
        job_acc++;
        if (cmd_type == 2'd2) begin
          job_d++;
          acks_owed++;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_desc: got type %0d addr 0x%0h, required none", cmd_type, cmd_addr);
        end else begin
          dsc = exp_q.pop_front();
          chk("desc_type", 64'(cmd_type), 64'(dsc.t));
          chk("desc_addr", cmd_addr, dsc.addr);
          chk("desc_len", 64'(cmd_len), 64'(dsc.len));
          chk("desc_last", 64'(cmd_tile_last), 64'(dsc.last));
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_addr  = cmd_addr;
      prev_misc  = {cmd_type, cmd_tile_last, cmd_len};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_start(input job_t j);
    @(posedge clk_pl); #1;
    M1 = j.m1[23:0]; M2 = j.m2[23:0]; M3 = j.m3[23:0]; batch = j.batch[15:0];
    addr_matrix_a = j.a; addr_matrix_b = j.b; addr_matrix_d = j.d;
    stride_a = j.sa; stride_b = j.sb; stride_d = j.sd;
    start = 1'b1;
    @(posedge clk_pl); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input job_t j, input string tag);
    int n_exp;
    build_exp(j);
    n_exp = exp_q.size();
    job_acc = 0; job_d = 0; log_q.delete();
    rnd_ready = j.rnd;
    ack_auto = !j.hold;
    drive_start(j);
    if (j.spur) spur_req = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_pl); #1;
      spur_req = 1'b0;
      if (j.hold && c == 150) begin
        chk({tag, "_stall_dcount"}, 64'(job_d), 64'(MAXO));
        chk({tag, "_stall_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_stall_busy"}, 64'(busy), 64'd1);
        ack_auto = 1'b1;
      end
      if (done) break;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_error"}, 64'(error), 64'(j.exp_err));
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_count_model"}, 64'(job_acc), 64'(n_exp));
    if (j.exp_n >= 0) chk({tag, "_count_table"}, 64'(job_acc), 64'(j.exp_n));
    chk({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_acks_done"}, 64'(acks_owed), 64'd0);
    rnd_ready = 1'b0;
    ack_auto = 1'b1;
  endtask

  job_t tbl[8];
  job_t jb;
  bit   found;

  initial begin
    tbl[0] = '{4, 4, 4, 1, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h0, 64'h0, 64'h0, 24, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4, 4, 4, 2, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h40, 64'h80, 64'h100, 48, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{3, 4, 4, 1, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h0, 64'h0, 64'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4, 0, 4, 1, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h0, 64'h0, 64'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4, 4, 5, 1, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h0, 64'h0, 64'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{4, 4, 4, 0, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h0, 64'h0, 64'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{2, 3, 6, 3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF00,
               64'h20, 64'hFFFF_FFFF_FFFF_FFE0, 64'h200, 54, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{4, 2, 8, 1, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h0, 64'h0, 64'h0, 48, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk_pl);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_fields", {cmd_addr[31:0], cmd_len[28:0], cmd_type, cmd_tile_last}, 64'd0);
    rst_pl = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i], $sformatf("job%0d", i));
      if (i == 0 && log_q.size() >= 11) begin
        chk("j0_first_a_addr", log_q[0].addr, 64'h1000_0000);
        chk("j0_first_a_len", 64'(log_q[0].len), 64'd4);
        chk("j0_second_a_addr", log_q[1].addr, 64'h1000_0004);
        chk("j0_first_b", {log_q[2].addr[61:0], log_q[2].t}, {62'h2000_0000, 2'd1});
        chk("j0_first_d", {log_q[4].addr[62:0], log_q[4].last}, {63'h3000_0000, 1'b0});
        chk("j0_first_d_len", 64'(log_q[4].len), 64'd8);
        chk("j0_second_d", {log_q[5].addr[62:0], log_q[5].last}, {63'h3000_0010, 1'b1});
        chk("j0_tile01_d", log_q[10].addr, 64'h3000_0008);
      end
      if (i == 1 && log_q.size() >= 29) begin
        chk("j1_batch1_first_d", log_q[28].addr, 64'h3000_0100);
      end
    end

    // Bad dimension: done and error two cycles after start, nothing issued.
    jb = tbl[2];
    job_acc = 0;
    drive_start(jb);
    @(posedge clk_pl); #1;
    chk("bad_done_early", 64'(done), 64'd0);
    chk("bad_busy", 64'(busy), 64'd1);
    @(posedge clk_pl); #1;
    chk("bad_done", 64'(done), 64'd1);
    chk("bad_error", 64'(error), 64'd1);
    chk("bad_busy_low", 64'(busy), 64'd0);
    chk("bad_no_desc", 64'(job_acc), 64'd0);

    // Reset while B reads are being issued abandons the job.
    jb = tbl[0];
    build_exp(jb);
    job_acc = 0;
    drive_start(jb);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (cmd_valid && cmd_type == 2'd1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk_pl); #1;
    end
    chk("midb_reached", 64'(found), 64'd1);
    rst_pl = 1'b1;
    @(posedge clk_pl); #1;
    @(posedge clk_pl); #1;
    chk("midb_rst_busy", 64'(busy), 64'd0);
    chk("midb_rst_valid", 64'(cmd_valid), 64'd0);
    chk("midb_rst_done", 64'(done), 64'd0);
    rst_pl = 1'b0;
    exp_q.delete();
    acks_owed = 0;
    job_acc = 0;
    repeat (5) @(posedge clk_pl);
    #1;
    chk("midb_quiet", 64'(job_acc), 64'd0);

    // Fresh job after reset with a spurious acknowledge during the check cycle.
    jb = tbl[0];
    jb.spur = 1'b1;
    jb.exp_err = 1'b1;
    run_job(jb, "spur");
    if (log_q.size() > 0) chk("spur_restart_addr", log_q[0].addr, 64'h1000_0000);

    // Random jobs with back-pressure.
    for (int k = 0; k < 5; k++) begin
      jb.m1 = 2 * $urandom_range(1, 3);
      jb.m2 = $urandom_range(1, 5);
      jb.m3 = 2 * $urandom_range(1, 3);
      jb.batch = $urandom_range(1, 3);
      jb.a  = {$urandom, $urandom};
      jb.b  = {$urandom, $urandom};
      jb.d  = {$urandom, $urandom};
      jb.sa = {$urandom, $urandom};
      jb.sb = {$urandom, $urandom};
      jb.sd = {$urandom, $urandom};
      jb.exp_n = -1;
      jb.exp_err = 1'b0;
      jb.rnd = 1'b1;
      jb.hold = 1'b0;
      jb.spur = 1'b0;
      run_job(jb, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_mm_tile_sched.md
Name: noc_mm_tile_sched

Overview:
- Tile scheduler for the next-generation NoC matrix multiply: computes D = A x B for `batch` independent problems, each M1xM2 times M2xM3.
- Walks output tiles of N1xN2 and issues NoC read descriptors for A row-panels and B column-panels, then write descriptors for D tile rows.
- Sits between the host-facing start/done/error control and the NoC DMA/systolic-array datapath.
- New versus the single-shot engine: batched operation with per-matrix batch strides, bounded outstanding-write credit tracking, and dimension checking.

Parameters:
- D_W, 8, input element width in bits (must be a multiple of 8).
- D_W_ACC, 32, output element width in bits (must be a multiple of 8).
- N1, 2, systolic array rows (tile height).
- N2, 2, systolic array columns (tile width).
- MATRIXSIZE_W, 24, width of the dimension inputs.
- ADDR_W, 64, NoC address width.
- MAX_OUT, 8, maximum unacknowledged D write descriptors (power of 2, at least 2).

Ports:
- clk_pl  in  1  PL clock.
- rst_pl  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done rises.
- done  out  1  sticky; cleared by the next accepted start.
- error  out  1  sticky; valid when done=1.
- M1, M2, M3  in  MATRIXSIZE_W each  dimensions; sampled on start.
- batch  in  16  number of problems; sampled on start.
- addr_matrix_a, addr_matrix_b, addr_matrix_d  in  ADDR_W each  base addresses.
- stride_a, stride_b, stride_d  in  ADDR_W each  byte offset between consecutive batch problems.
- cmd_valid  out  1  descriptor valid.
- cmd_ready  in  1  descriptor accepted when cmd_valid and cmd_ready are both high.
- cmd_type  out  2  0 = A read, 1 = B read, 2 = D write.
- cmd_addr  out  ADDR_W  byte address.
- cmd_len  out  32  byte length.
- cmd_tile_last  out  1  high on the final D descriptor of a tile.
- wr_ack  in  1  one pulse per completed D write descriptor.

Behaviour:
- Reset: every output 0, FSM in IDLE, counters and outstanding count cleared. Reset mid-operation abandons the job without any further descriptors.
- Layout:
  - A is row-major, bytes per element EA = D_W/8.
  - B is stored transposed (row j holds column j), EA bytes per element.
  - D is row-major, ED = D_W_ACC/8.
  - All address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W.
- FSM: IDLE -> CHECK -> ISSUE_A -> ISSUE_B -> ISSUE_D -> NEXT -> (ISSUE_A | DRAIN) -> FIN -> IDLE.
  - IDLE: on start, latch all inputs, clear done and error, set busy.
  - CHECK (1 cycle): go to FIN with error=1 if any of M1, M2, M3 or batch is 0, or if M1 % N1 != 0 or M3 % N2 != 0. Otherwise go to ISSUE_A.
  - ISSUE_A: N1 descriptors, r = 0..N1-1. Address = base_a + bi*stride_a + (ti*N1 + r)*M2*EA. Length = M2*EA.
  - ISSUE_B: N2 descriptors, c = 0..N2-1. Address = base_b + bi*stride_b + (tj*N2 + c)*M2*EA. Length = M2*EA.
  - ISSUE_D: N1 descriptors. Address = base_d + bi*stride_d + ((ti*N1 + r)*M3 + tj*N2)*ED. Length = N2*ED. cmd_tile_last is high for r = N1-1. cmd_valid is held low while outstanding == MAX_OUT.
  - NEXT (1 cycle): advance tj, then ti, then bi. Go to DRAIN once all are exhausted.
  - DRAIN: wait until outstanding == 0.
  - FIN: set done=1, clear busy, go to IDLE.
- Handshake: once cmd_valid is high, cmd_valid and all cmd_* fields hold stable until accepted. Back-to-back acceptance gives one descriptor per cycle.
- Outstanding counter: +1 on each D acceptance, -1 on wr_ack. Both in the same cycle leave it unchanged.
- A wr_ack with outstanding == 0 is spurious: set error=1, leave the count at 0, and continue the job.
- Total descriptors: batch*(M1/N1)*(M3/N2)*(2*N1+N2).

Decomposition:
- Package noc_mm_pkg holds:
  - cmd_type constants (CMD_A, CMD_B, CMD_D);
  - the FSM state enum;
  - element-byte helper constants.
- One sub-module, noc_mm_credit_cnt: an up/down counter with full flag, empty flag and underflow pulse, parameterised by MAX_OUT.

Test Plan:
- 4x4x4, N1=N2=2, batch=1, A=0x1000_0000, B=0x2000_0000, D=0x3000_0000, cmd_ready=1, wr_ack one cycle after each D acceptance.
  - Exactly 24 descriptors.
  - First three: A 0x1000_0000 len 4, A 0x1000_0004, B 0x2000_0000.
  - First D 0x3000_0000 len 8; second D 0x3000_0010 with cmd_tile_last=1.
  - Tile (0,1) first D 0x3000_0008.
  - done=1, error=0.
- Same job with batch=2, stride_d=0x100: 48 descriptors; first D of batch 1 at 0x3000_0100.
- M1=3 (not a multiple of N1): no descriptors, done=1 and error=1 two cycles after start.
- wr_ack withheld, cmd_ready=1: cmd_valid drops after 8 D descriptors; releasing acks resumes issue; done only after the final ack.
- Random cmd_ready back-pressure: cmd_addr, cmd_len and cmd_type stay stable while cmd_valid && !cmd_ready.
- Reset asserted mid-ISSUE_B, then a new start: clean restart from tile (0,0); spurious wr_ack in IDLE-started job sets error=1.
